// File: rtl/aes_core_sched_pkg.sv
// Shared widths, state encodings and defaults for the AES sequencer.
package aes_core_sched_pkg;
    localparam int KEY_S = 128;
    localparam int BLK_S = 128;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/aes_out_fifo.sv
// Two-entry ciphertext queue; head is visible on out_data/out_valid.
module aes_out_fifo #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];
    assign valid   = (count != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/aes_core_sched.sv
// Command sequencer in front of the AES core: key tracking, start
// pulses, completion watchdog and buffered ciphertext output.
module aes_core_sched
    import aes_core_sched_pkg::*;
#(
    parameter int KEY_W   = KEY_S,
    parameter int BLK_W   = BLK_S,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_key_load,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             core_en,
    output logic             core_key_strobe,
    output logic [KEY_W-1:0] core_key,
    output logic [BLK_W-1:0] core_plaintext,
    input  logic [BLK_W-1:0] core_ciphertext,
    input  logic             core_done,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] blk_count
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t     state;
    state_t     state_nx;
    logic [TMR_W-1:0] timer;
    logic       key_dirty;
    logic       ready_en;
    logic [1:0] q_count;
    logic       accept;
    logic       push;
    logic       pop;
    logic       timed_out;

    assign accept    = in_valid && in_ready;
    assign push      = (state == WAIT) && core_done;
    assign pop       = out_valid && out_ready;
    assign timed_out = (state == WAIT) && !core_done &&
                       (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && !in_key_load) begin
                    state_nx = START;
                end
            end
            START: state_nx = WAIT;
            WAIT: begin
                if (core_done || timed_out) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ready_en holds in_ready low through reset and its first cycle out
    always_comb begin
        in_ready = ready_en && (state == IDLE) && !err_timeout &&
                   (q_count < 2'd2);
        core_en         = (state == START);
        core_key_strobe = (state == START) && key_dirty;
        busy            = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_key       <= '0;
            core_plaintext <= '0;
            key_dirty      <= 1'b1;
            err_timeout    <= 1'b0;
            blk_count      <= '0;
            timer          <= '0;
            ready_en       <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept && in_key_load) begin
                core_key  <= in_data[KEY_W-1:0];
                key_dirty <= 1'b1;
            end
            if (accept && !in_key_load) begin
                core_plaintext <= in_data;
            end
            if (state == START) begin
                key_dirty <= 1'b0;
                timer     <= '0;
            end
            if (state == WAIT) begin
                timer <= timer + 1'b1;
            end
            if (timed_out) begin
                err_timeout <= 1'b1;
            end
            if (push) begin
                blk_count <= blk_count + 1'b1;
            end
        end
    end

    aes_out_fifo #(
        .W(BLK_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (core_ciphertext),
        .pop       (pop),
        .head      (out_data),
        .valid     (out_valid),
        .count     (q_count)
    );
endmodule

// File: tb/tb_aes_core_sched.sv
// Bench for aes_core_sched: behavioural core model, vector table and
// scoreboards for ciphertext order and key-strobe usage.
module tb_aes_core_sched;
    localparam int TO  = 16;
    localparam int LAT = 4;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 0;
    logic reset = 1;
    logic in_valid = 0;
    logic in_ready;
    logic in_key_load = 0;
    logic [127:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1;
    logic [127:0] out_data;
    logic core_en;
    logic core_key_strobe;
    logic [127:0] core_key;
    logic [127:0] core_plaintext;
    logic [127:0] core_ciphertext;
    logic core_done;
    logic busy;
    logic err_timeout;
    logic [31:0] blk_count;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb[$];
    logic sq[$];
    logic hang = 0;

    always #5 clk = ~clk;

    aes_core_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_key_load(in_key_load), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
        .core_en(core_en), .core_key_strobe(core_key_strobe),
        .core_key(core_key), .core_plaintext(core_plaintext),
        .core_ciphertext(core_ciphertext), .core_done(core_done),
        .busy(busy), .err_timeout(err_timeout),
        .blk_count(blk_count)
    );

    function automatic logic [127:0] cipher(logic [127:0] k, logic [127:0] p);
        if (k == K1 && p == P1) return FIPS;
        return p ^ {k[63:0], k[127:64]} ^ 128'ha5a5_0f0f_3c3c_9696_5a5a_f0f0_c3c3_6969;
    endfunction

    // core model: only re-expands the key when the strobe says so
    logic [127:0] exp_key;
    logic [127:0] pt_lat;
    int cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_key <= '0; pt_lat <= '0; cnt <= 0;
            core_done <= 0; core_ciphertext <= '0;
        end else begin
            core_done <= 0;
            if (core_en) begin
                if (core_key_strobe) exp_key <= core_key;
                pt_lat <= core_plaintext;
                cnt <= LAT;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1 && !hang) begin
                    core_done <= 1;
                    core_ciphertext <= cipher(exp_key, pt_lat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) fail("unexpected_output");
            else chk("out_data", out_data, sb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (reset && core_en) begin
            if (sq.size() == 0) fail("unexpected_core_en");
            else chk("key_strobe", 128'(core_key_strobe), 128'(sq.pop_front()));
        end
    end

    task automatic offer(input logic k, input logic [127:0] d,
                         input int budget, output logic acc);
        @(posedge clk); #1;
        in_valid = 1; in_key_load = k; in_data = d; acc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin acc = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_sig(input int which, input int budget, input string name);
        int n = 0;
        while (n < budget) begin
            if (which == 0 && out_valid) return;
            if (which == 1 && core_en) return;
            if (which == 2 && core_done) return;
            if (which == 3 && sb.size() == 0 && !busy && !out_valid) return;
            @(posedge clk); #1;
            n++;
        end
        fail(name);
    endtask

    typedef struct {
        logic is_key;
        logic [127:0] data;
        logic strobe;
        logic [127:0] ct;
    } vec_t;

    vec_t vt[8];
    logic acc;
    logic [127:0] ct_b;
    int nblk;

    initial begin
        vt[0] = '{1'b1, K1, 1'b0, '0};
        vt[1] = '{1'b0, P1, 1'b1, FIPS};
        vt[2] = '{1'b0, P1, 1'b0, FIPS};
        vt[3] = '{1'b1, K1, 1'b0, '0};
        vt[4] = '{1'b0, P2, 1'b1, cipher(K1, P2)};
        vt[5] = '{1'b1, K2, 1'b0, '0};
        vt[6] = '{1'b0, P1, 1'b1, cipher(K2, P1)};
        vt[7] = '{1'b0, P2, 1'b0, cipher(K2, P2)};

        #2 reset = 0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_core_en", 128'(core_en), 0);
        chk("rst_strobe", 128'(core_key_strobe), 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_pt", core_plaintext, 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_err", 128'(err_timeout), 0);
        chk("rst_blk_count", 128'(blk_count), 0);
        chk("rst_in_ready", 128'(in_ready), 0);
        #20 reset = 1;

        nblk = 0;
        for (int i = 0; i < 8; i++) begin
            if (!vt[i].is_key) begin
                sq.push_back(vt[i].strobe);
                sb.push_back(vt[i].ct);
                nblk++;
            end
            offer(vt[i].is_key, vt[i].data, 20, acc);
            chk($sformatf("accept_%0d", i), 128'(acc), 1);
            wait_sig(3, 40, "drain_vec");
            chk($sformatf("blk_count_%0d", i), 128'(blk_count), 128'(nblk));
        end

        // backpressure: two blocks fill the queue, third stalls
        out_ready = 0;
        sq.push_back(0); sb.push_back(cipher(K2, P2));
        offer(0, P2, 20, acc);
        chk("bp_acc1", 128'(acc), 1);
        sq.push_back(0); sb.push_back(cipher(K2, 128'h1));
        offer(0, 128'h1, 40, acc);
        chk("bp_acc2", 128'(acc), 1);
        offer(0, 128'h2, 30, acc);
        chk("bp_acc3_stall", 128'(acc), 0);
        chk("bp_in_ready", 128'(in_ready), 0);
        chk("bp_out_valid", 128'(out_valid), 1);
        @(posedge clk); #1 out_ready = 1;
        sq.push_back(0); sb.push_back(cipher(K2, 128'h2));
        offer(0, 128'h2, 40, acc);
        chk("bp_acc3", 128'(acc), 1);
        wait_sig(3, 60, "drain_bp");
        nblk += 3;
        chk("bp_blk_count", 128'(blk_count), 128'(nblk));

        // push and pop in the same cycle with one entry queued
        out_ready = 0;
        sq.push_back(0); sb.push_back(cipher(K2, 128'h3));
        offer(0, 128'h3, 20, acc);
        wait_sig(0, 40, "pp_first_valid");
        ct_b = cipher(K2, 128'h4);
        sq.push_back(0); sb.push_back(ct_b);
        offer(0, 128'h4, 20, acc);
        chk("pp_acc", 128'(acc), 1);
        wait_sig(2, 40, "pp_done");
        out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        chk("pp_valid", 128'(out_valid), 1);
        chk("pp_head", out_data, ct_b);
        out_ready = 1;
        @(posedge clk); #1;
        chk("pp_empty", 128'(out_valid), 0);
        wait_sig(3, 40, "drain_pp");

        // reset in WAIT with one block queued
        out_ready = 0;
        sq.push_back(0); sb.push_back(cipher(K2, 128'h5));
        offer(0, 128'h5, 20, acc);
        wait_sig(0, 40, "rw_valid");
        sq.push_back(0);
        offer(0, 128'h6, 20, acc);
        wait_sig(1, 10, "rw_core_en");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rw_busy_before", 128'(busy), 1);
        reset = 0;
        #1;
        chk("rw_out_valid", 128'(out_valid), 0);
        chk("rw_busy", 128'(busy), 0);
        chk("rw_blk_count", 128'(blk_count), 0);
        sb.delete(); sq.delete();
        #20 reset = 1;
        out_ready = 1;
        sq.push_back(1); sb.push_back(cipher(128'h0, P1));
        offer(0, P1, 20, acc);
        chk("rw_acc", 128'(acc), 1);
        wait_sig(3, 40, "drain_rw");
        chk("rw_blk_after", 128'(blk_count), 1);

        // watchdog: core never answers
        hang = 1;
        sq.push_back(0);
        offer(0, P2, 20, acc);
        wait_sig(1, 10, "to_core_en");
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1 chk("to_err_early", 128'(err_timeout), 0);
        @(posedge clk); #1;
        chk("to_err", 128'(err_timeout), 1);
        chk("to_busy", 128'(busy), 0);
        chk("to_in_ready", 128'(in_ready), 0);
        offer(0, P1, 20, acc);
        chk("to_no_accept", 128'(acc), 0);
        chk("to_out_valid", 128'(out_valid), 0);
        chk("to_err_sticky", 128'(err_timeout), 1);
        chk("to_blk_count", 128'(blk_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
